// File: rtl/xorn_pkg.sv
// Shared encodings for the xorn_accum block: operation modes and output-stage states.
package xorn_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/xor_gate.sv
// Single-bit XOR cell; the xorn_accum datapath is built from arrays of these.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xorn_accum.sv
// XOR/XNOR/accumulate unit with a one-entry ready/valid output stage.
// Optional registered parity output is enabled by defining XORN_PARITY_EN.
module xorn_accum
  import xorn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef XORN_PARITY_EN
  output logic             parity,
`endif
  output logic [CNTW-1:0]  cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == {CNTW{1'b1}}) return v;
    return v + CNTW'(1);
  endfunction

  state_e           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_acc;
  logic [CNTW-1:0]  r_cnt;

  mode_e            w_mode;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_accv;
  logic [WIDTH-1:0] w_res;

  assign w_mode   = mode_e'(mode);
  assign in_ready = (r_state == ST_EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;

  // A coincident clear makes the accumulate start from zero, so clr+ACC folds into an empty acc.
  assign w_acc_base = clr ? '0 : r_acc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_gate u_op  (.a(in1[i]),        .b(in2[i]), .y(w_x[i]));
    xor_gate u_acc (.a(w_acc_base[i]), .b(w_x[i]), .y(w_accv[i]));
  end

  always_comb begin
    w_res = w_x;
    case (w_mode)
      MODE_XNOR: w_res = ~w_x;
      MODE_ACC:  w_res = w_accv;
      default:   w_res = w_x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_state <= ST_FULL;
        r_out   <= w_res;
      end else if (out_ready) begin
        r_state <= ST_EMPTY;
      end

      if (w_accept && w_mode == MODE_LOAD) begin
        r_acc <= w_x;
        r_cnt <= CNTW'(1);
      end else if (w_accept && w_mode == MODE_ACC) begin
        r_acc <= w_accv;
        r_cnt <= clr ? CNTW'(1) : sat_inc(r_cnt);
      end else if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

`ifdef XORN_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_parity <= 1'b0;
    else if (w_accept) r_parity <= ^w_res;
  end

  assign parity = r_parity;
`endif

  assign out_valid = (r_state == ST_FULL);
  assign out       = r_out;
  assign cnt       = r_cnt;

endmodule

// File: tb/tb_xorn_accum.sv
// Directed bench for xorn_accum: vector table plus hand-written multi-cycle sequences.
module tb_xorn_accum;
  import xorn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] mode = 2'b00;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic       clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out;
  logic [7:0] cnt;
`ifdef XORN_PARITY_EN
  logic       parity;
  logic       parity2;
`endif

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out2;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xorn_accum #(.WIDTH(8), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in1(in1), .in2(in2), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
`ifdef XORN_PARITY_EN
    .parity(parity),
`endif
    .cnt(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  xorn_accum #(.WIDTH(8), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .mode(mode), .in1(in1), .in2(in2), .clr(clr),
    .out_valid(out_valid2), .out_ready(out_ready), .out(out2),
`ifdef XORN_PARITY_EN
    .parity(parity2),
`endif
    .cnt(cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic c, input logic ordy);
    in_valid  = v;
    mode      = m;
    in1       = a;
    in2       = b;
    clr       = c;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_out;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{MODE_XOR,  8'hA5, 8'h0F, 1'b0, 8'hAA, 8'd0};
    tbl[1]  = '{MODE_XNOR, 8'hA5, 8'h0F, 1'b0, 8'h55, 8'd0};
    tbl[2]  = '{MODE_LOAD, 8'h12, 8'h00, 1'b0, 8'h12, 8'd1};
    tbl[3]  = '{MODE_ACC,  8'h34, 8'h00, 1'b0, 8'h26, 8'd2};
    tbl[4]  = '{MODE_ACC,  8'h56, 8'h00, 1'b0, 8'h70, 8'd3};
    tbl[5]  = '{MODE_XOR,  8'h01, 8'h02, 1'b0, 8'h03, 8'd3};
    tbl[6]  = '{MODE_ACC,  8'h00, 8'h00, 1'b0, 8'h70, 8'd4};
    tbl[7]  = '{MODE_LOAD, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'd1};
    tbl[8]  = '{MODE_ACC,  8'h0F, 8'h00, 1'b1, 8'h0F, 8'd1};
    tbl[9]  = '{MODE_ACC,  8'h00, 8'hF0, 1'b0, 8'hFF, 8'd2};
    tbl[10] = '{MODE_LOAD, 8'h12, 8'h34, 1'b1, 8'h26, 8'd1};
    tbl[11] = '{MODE_XOR,  8'h07, 8'h00, 1'b0, 8'h07, 8'd1};

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 8'h00);
    check("rst_cnt", cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1);
      tick();
      check($sformatf("vec%0d_out", i), out, tbl[i].exp_out);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_cnt", i), cnt, tbl[i].exp_cnt);
`ifdef XORN_PARITY_EN
      check($sformatf("vec%0d_parity", i), parity, ^tbl[i].exp_out);
`endif
    end

    // Backpressure: result 0x07 held, new pair offered but refused
    drive(1'b1, MODE_XOR, 8'hC3, 8'h00, 1'b0, 1'b0);
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_out%0d", k), out, 8'h07);
      check($sformatf("bp_hold_valid%0d", k), out_valid, 1);
    end
    drive(1'b1, MODE_XOR, 8'h3C, 8'h00, 1'b0, 1'b1);
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_release_out", out, 8'h3C);
    check("bp_release_valid", out_valid, 1);
    check("bp_cnt_kept", cnt, 1);

    // Drain: FULL -> EMPTY with no accept
    drive(1'b0, MODE_ACC, 8'hEE, 8'h11, 1'b0, 1'b1);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_out", out, 8'h3C);
    check("drain_cnt", cnt, 1);

    // Clear alone: acc/cnt zeroed, output stage untouched
    drive(1'b1, MODE_LOAD, 8'h5A, 8'h00, 1'b0, 1'b0);
    tick();
    drive(1'b0, MODE_ACC, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    check("clr_out", out, 8'h5A);
    check("clr_valid", out_valid, 1);
    check("clr_cnt", cnt, 0);
    drive(1'b1, MODE_ACC, 8'h01, 8'h00, 1'b0, 1'b1);
    tick();
    check("clr_acc_zero", out, 8'h01);
    check("clr_acc_cnt", cnt, 1);

    // Saturation on the CNTW=2 instance
    drive(1'b1, MODE_LOAD, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    check("sat_load_cnt", cnt2, 1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, MODE_ACC, 8'h00, 8'h00, 1'b0, 1'b1);
      tick();
      check($sformatf("sat_acc%0d_cnt", k), cnt2, (k == 0) ? 2 : 3);
    end
    check("sat_wide_cnt", cnt, 6);

    // Reset mid-operation while FULL
    drive(1'b1, MODE_LOAD, 8'h99, 8'h00, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", out_valid, 1);
    drive(1'b0, MODE_XOR, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", out, 8'h00);
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
`ifdef XORN_PARITY_EN
    check("mid_rst_parity", parity, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, MODE_XOR, 8'h11, 8'h22, 1'b0, 1'b1);
    tick();
    check("post_rst_out", out, 8'h33);
    check("post_rst_valid", out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
